// File: rtl/dm_port_arbiter.sv
// Shares the single-port data memory between the CPU MEM stage (priority) and a DMA/debug burst loader.
// Optional build macro DM_ARB_STATS_EN adds a saturating stall_cnt output.
module dm_port_arbiter #(
   parameter int AW       = 7,
   parameter int DW       = 32,
   parameter int LENW     = 4,
   parameter int MAX_WAIT = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [AW-1:0]   cpu_addr,
   input  logic            cpu_rd,
   input  logic            cpu_wr,
   input  logic [DW-1:0]   cpu_wdata,
   output logic [DW-1:0]   cpu_rdata,
   output logic            cpu_stall,
   input  logic            dma_req,
   input  logic            dma_wr,
   input  logic [AW-1:0]   dma_addr,
   input  logic [LENW-1:0] dma_len,
   input  logic [DW-1:0]   dma_wdata,
   output logic [DW-1:0]   dma_rdata,
   output logic            dma_gnt,
   output logic            dma_ack,
   output logic            dma_done,
   output logic [AW-1:0]   mem_addr,
   output logic            mem_rd,
   output logic            mem_wr,
   output logic [DW-1:0]   mem_wdata,
   input  logic [DW-1:0]   mem_rdata,
`ifdef DM_ARB_STATS_EN
   output logic [15:0]     stall_cnt,
`endif
   output logic [1:0]      dbg_state
);

   // Handshake: there is no DMA backpressure. While dma_gnt is high one beat is
   // performed every cycle (dma_ack); a CPU access is taken only when cpu_stall is low.

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WAIT  = 2'd1,
      S_BURST = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam int WW = $clog2(MAX_WAIT + 1);

   state_t          state;
   logic [LENW-1:0] beat;
   logic [LENW-1:0] lat_len;
   logic [WW-1:0]   wait_cnt;
   logic [AW-1:0]   lat_addr;
   logic            lat_wr;
   logic            gnt_q;
   logic            done_q;
   logic            cpu_acc;

   assign cpu_acc = cpu_rd | cpu_wr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         beat     <= '0;
         lat_len  <= '0;
         wait_cnt <= '0;
         lat_addr <= '0;
         lat_wr   <= 1'b0;
         gnt_q    <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (dma_req) begin
                  if (cpu_acc) begin
                     state    <= S_WAIT;
                     wait_cnt <= WW'(1);
                  end else begin
                     state    <= S_BURST;
                     gnt_q    <= 1'b1;
                     lat_addr <= dma_addr;
                     lat_len  <= dma_len;
                     lat_wr   <= dma_wr;
                     beat     <= '0;
                  end
               end
            end
            S_WAIT: begin
               // A withdrawn request abandons the burst before any beat is issued.
               if (!dma_req) begin
                  state    <= S_IDLE;
                  wait_cnt <= '0;
               end else if (!cpu_acc || wait_cnt == WW'(MAX_WAIT)) begin
                  state    <= S_BURST;
                  gnt_q    <= 1'b1;
                  lat_addr <= dma_addr;
                  lat_len  <= dma_len;
                  lat_wr   <= dma_wr;
                  beat     <= '0;
                  wait_cnt <= '0;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            S_BURST: begin
               if (beat == lat_len) begin
                  state  <= S_DONE;
                  gnt_q  <= 1'b0;
                  done_q <= 1'b1;
               end else begin
                  beat <= beat + 1'b1;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
               gnt_q <= 1'b0;
            end
         endcase
      end
   end

   // The memory port follows the CPU except while a burst owns it.
   always_comb begin
      mem_addr  = cpu_addr;
      mem_rd    = cpu_rd;
      mem_wr    = cpu_wr;
      mem_wdata = cpu_wdata;
      cpu_stall = 1'b0;
      if (gnt_q) begin
         mem_addr  = lat_addr + AW'(beat);
         mem_rd    = ~lat_wr;
         mem_wr    = lat_wr;
         mem_wdata = dma_wdata;
         cpu_stall = cpu_acc;
      end
   end

   assign cpu_rdata = mem_rdata;
   assign dma_rdata = mem_rdata;
   assign dma_gnt   = gnt_q;
   assign dma_ack   = gnt_q;
   assign dma_done  = done_q;
   assign dbg_state = state;

`ifdef DM_ARB_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
      end else if (cpu_stall && stall_cnt != 16'hFFFF) begin
         stall_cnt <= stall_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Randomized scoreboard bench for dm_port_arbiter: episodes are planned from the arbitration
// rules, expected memory events are queued, and a negedge monitor pops and compares them.
module tb_dm_port_arbiter;

   localparam int AW       = 7;
   localparam int DW       = 32;
   localparam int LENW     = 4;
   localparam int MAX_WAIT = 4;
   localparam int DEPTH    = 1 << AW;
   localparam int PMAX     = 48;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [AW-1:0]   cpu_addr = '0;
   logic            cpu_rd = 1'b0;
   logic            cpu_wr = 1'b0;
   logic [DW-1:0]   cpu_wdata = '0;
   logic [DW-1:0]   cpu_rdata;
   logic            cpu_stall;
   logic            dma_req = 1'b0;
   logic            dma_wr = 1'b0;
   logic [AW-1:0]   dma_addr = '0;
   logic [LENW-1:0] dma_len = '0;
   logic [DW-1:0]   dma_wdata = '0;
   logic [DW-1:0]   dma_rdata;
   logic            dma_gnt;
   logic            dma_ack;
   logic            dma_done;
   logic [AW-1:0]   mem_addr;
   logic            mem_rd;
   logic            mem_wr;
   logic [DW-1:0]   mem_wdata;
   logic [DW-1:0]   mem_rdata;
   logic [1:0]      dbg_state;
`ifdef DM_ARB_STATS_EN
   logic [15:0]     stall_cnt;
`endif

   dm_port_arbiter #(.AW(AW), .DW(DW), .LENW(LENW), .MAX_WAIT(MAX_WAIT)) dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .dma_req(dma_req), .dma_wr(dma_wr), .dma_addr(dma_addr), .dma_len(dma_len),
      .dma_wdata(dma_wdata), .dma_rdata(dma_rdata), .dma_gnt(dma_gnt), .dma_ack(dma_ack),
      .dma_done(dma_done),
      .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata),
`ifdef DM_ARB_STATS_EN
      .stall_cnt(stall_cnt),
`endif
      .dbg_state(dbg_state)
   );

   // ---------------- clock / reset / memory ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [DW-1:0] dm [DEPTH];
   assign mem_rdata = dm[mem_addr];
   always @(posedge clk) if (mem_wr) dm[mem_addr] <= mem_wdata;

   // ---------------- scoreboard ----------------
   typedef struct {
      int            kind;   // 0 = DMA beat, 1 = dma_done, 2 = CPU access served
      int            cyc;
      logic [AW-1:0] addr;
      logic          wr;
      logic [DW-1:0] data;
   } ev_t;

   ev_t           exp_q[$];
   logic [DW-1:0] shadow [DEPTH];
   int            checks = 0;
   int            errors = 0;
   int            stall_model = 0;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic take(input int kind);
      ev_t e;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL unexpected_event at cycle %0d: got event kind %0d, expected none", cyc, kind);
         return;
      end
      e = exp_q.pop_front();
      chk("event_kind", 32'(kind), 32'(e.kind));
      chk("event_cycle", 32'(cyc), 32'(e.cyc));
      chk("dma_gnt", 32'(dma_gnt), 32'(kind == 0));
      if (kind == 1) return;
      chk("mem_addr", 32'(mem_addr), 32'(e.addr));
      chk("mem_wr", 32'(mem_wr), 32'(e.wr));
      chk("mem_rd", 32'(mem_rd), 32'(!e.wr));
      if (e.wr)           chk("mem_wdata", mem_wdata, e.data);
      else if (kind == 0) chk("dma_rdata", dma_rdata, e.data);
      else                chk("cpu_rdata", cpu_rdata, e.data);
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (dma_ack) take(0);
         if (dma_done) take(1);
         if ((cpu_rd || cpu_wr) && !cpu_stall) take(2);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         cpu_rd = 1'b0; cpu_wr = 1'b0; dma_req = 1'b0;
      end
   endtask

   task automatic cpu_op(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
      ev_t e;
      @(posedge clk); #1;
      e.kind = 2; e.cyc = cyc; e.addr = a; e.wr = wr;
      e.data = wr ? d : shadow[a];
      if (wr) shadow[a] = d;
      exp_q.push_back(e);
      cpu_rd = !wr; cpu_wr = wr; cpu_addr = a; cpu_wdata = d; dma_req = 1'b0;
   endtask

   // One episode: an optional DMA request raised in cycle 0 against a CPU activity
   // pattern (0 random, 1 always busy, 2 idle). Expected events come from the rules:
   // grant edge g, beats in cycles g+1..g+1+len, done in g+len+2.
   task automatic run_episode(input bit dma_en, input bit d_wr, input logic [AW-1:0] d_addr,
                              input logic [LENW-1:0] d_len, input int busy_mode,
                              input bit drop, input int cpu_len);
      bit            busy [PMAX];
      logic          p_req [PMAX], p_wr [PMAX], p_crd [PMAX], p_cwr [PMAX];
      logic [AW-1:0] p_addr [PMAX], p_caddr [PMAX];
      logic [LENW-1:0] p_len [PMAX];
      logic [DW-1:0] p_wdata [PMAX], p_cwdata [PMAX];
      ev_t           loc_q[$];
      ev_t           e;
      int            g, drop_at, n, len, base;
      bit            op_pend, op_wr, burst, done_c, acc;
      logic [AW-1:0] op_addr, a;
      logic [DW-1:0] op_data;

      g = 0; drop_at = 0; len = int'(d_len);
      op_pend = 1'b0; op_wr = 1'b0; op_addr = '0; op_data = '0;
      for (int i = 0; i < PMAX; i++)
         busy[i] = (busy_mode == 1) ? 1'b1 : (busy_mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
      if (dma_en) begin
         if (busy[0]) begin
            g = MAX_WAIT;
            for (int c = MAX_WAIT - 1; c >= 1; c--) if (!busy[c]) g = c;
            if (drop) drop_at = int'($urandom_range(1, g));
         end
         n = (drop_at > 0) ? drop_at + 1 : g + len + 3;
      end else begin
         n = cpu_len;
      end

      for (int c = 0; c < n; c++) begin
         burst  = dma_en && drop_at == 0 && c > g && c <= g + 1 + len;
         done_c = dma_en && drop_at == 0 && c == g + len + 2;
         if (!dma_en)          p_req[c] = 1'b0;
         else if (drop_at > 0) p_req[c] = (c < drop_at);
         else                  p_req[c] = (c <= g) ? 1'b1 : 1'($urandom_range(0, 1));
         if (dma_en && drop_at == 0 && c == g) begin
            p_wr[c] = d_wr; p_addr[c] = d_addr; p_len[c] = d_len;
         end else begin
            p_wr[c]   = 1'($urandom_range(0, 1));
            p_addr[c] = AW'($urandom_range(0, DEPTH - 1));
            p_len[c]  = LENW'($urandom_range(0, 15));
         end
         p_wdata[c] = $urandom;
         acc = busy[c] | op_pend;
         if (acc && !op_pend) begin
            op_pend = 1'b1;
            op_wr   = 1'($urandom_range(0, 1));
            op_addr = AW'($urandom_range(0, DEPTH - 1));
            op_data = $urandom;
         end
         p_crd[c]    = acc && !op_wr;
         p_cwr[c]    = acc && op_wr;
         p_caddr[c]  = acc ? op_addr : AW'($urandom_range(0, DEPTH - 1));
         p_cwdata[c] = acc ? op_data : $urandom;
         if (burst) begin
            a = d_addr + AW'(c - g - 1);
            e.kind = 0; e.cyc = c; e.addr = a; e.wr = d_wr;
            if (d_wr) begin
               e.data = p_wdata[c];
               shadow[a] = p_wdata[c];
            end else begin
               e.data = shadow[a];
            end
            loc_q.push_back(e);
            if (acc) stall_model++;
         end
         if (done_c) begin
            e.kind = 1; e.cyc = c; e.addr = '0; e.wr = 1'b0; e.data = '0;
            loc_q.push_back(e);
         end
         if (acc && !burst) begin
            e.kind = 2; e.cyc = c; e.addr = op_addr; e.wr = op_wr;
            if (op_wr) begin
               e.data = op_data;
               shadow[op_addr] = op_data;
            end else begin
               e.data = shadow[op_addr];
            end
            loc_q.push_back(e);
            op_pend = 1'b0;
         end
      end

      @(posedge clk); #1;
      base = cyc;
      foreach (loc_q[i]) begin
         e = loc_q[i];
         e.cyc = e.cyc + base;
         exp_q.push_back(e);
      end
      for (int c = 0; c < n; c++) begin
         if (c > 0) begin
            @(posedge clk); #1;
         end
         dma_req = p_req[c]; dma_wr = p_wr[c]; dma_addr = p_addr[c]; dma_len = p_len[c];
         dma_wdata = p_wdata[c];
         cpu_rd = p_crd[c]; cpu_wr = p_cwr[c]; cpu_addr = p_caddr[c]; cpu_wdata = p_cwdata[c];
      end
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [DW-1:0] v;
      logic [DW-1:0] w [4];
      ev_t           e;
      int            diff;

      for (int i = 0; i < DEPTH; i++) begin
         v = $urandom;
         dm[i] <= v;
         shadow[i] = v;
      end

      // Reset: flags low, memory port mirrors the CPU.
      rst_n = 1'b0;
      cpu_rd = 1'b1; cpu_addr = 7'h5A; cpu_wdata = 32'h1234_5678; dma_req = 1'b1;
      #2;
      chk("reset_dma_gnt", 32'(dma_gnt), 32'd0);
      chk("reset_dma_ack", 32'(dma_ack), 32'd0);
      chk("reset_dma_done", 32'(dma_done), 32'd0);
      chk("reset_cpu_stall", 32'(cpu_stall), 32'd0);
      chk("reset_mem_addr", 32'(mem_addr), 32'h5A);
      chk("reset_mem_rd", 32'(mem_rd), 32'd1);
      chk("reset_cpu_rdata", cpu_rdata, shadow[7'h5A]);
      repeat (2) @(posedge clk);
      #1; cpu_rd = 1'b0; dma_req = 1'b0;
      @(negedge clk); #1;
      rst_n = 1'b1;

      // CPU only: store then load the same word.
      cpu_op(1'b1, 7'h05, 32'hDEAD_BEEF);
      cpu_op(1'b0, 7'h05, 32'h0);
      idle(2);
      run_episode(1'b0, 1'b0, '0, '0, 0, 1'b0, 12);
      // CPU idle, write burst of 4 at 0x10.
      run_episode(1'b1, 1'b1, 7'h10, 4'd3, 2, 1'b0, 0);
      // CPU busy every cycle: full wait, stalled CPU ops finish in DONE.
      run_episode(1'b1, 1'b1, 7'h30, 4'd5, 1, 1'b0, 0);
      // Read burst wrapping past the top of memory.
      run_episode(1'b1, 1'b0, 7'h7E, 4'd3, 2, 1'b0, 0);
      // Request withdrawn while waiting.
      run_episode(1'b1, 1'b1, 7'h40, 4'd2, 1, 1'b1, 0);
      // Back-to-back bursts.
      run_episode(1'b1, 1'b1, 7'h7F, 4'd15, 0, 1'b0, 0);
      run_episode(1'b1, 1'b0, 7'h7F, 4'd0, 0, 1'b0, 0);

      for (int k = 0; k < 160; k++) begin
         logic [AW-1:0] ra;
         ra = ($urandom_range(0, 3) == 0) ? AW'(7'h7C + AW'($urandom_range(0, 3)))
                                          : AW'($urandom_range(0, DEPTH - 1));
         run_episode(1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 1)), ra,
                     LENW'($urandom_range(0, 15)), int'($urandom_range(0, 2)),
                     1'($urandom_range(0, 3) == 0), int'($urandom_range(1, 8)));
      end
      idle(4);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
`ifdef DM_ARB_STATS_EN
      chk("stall_cnt", 32'(stall_cnt), 32'((stall_model > 65535) ? 65535 : stall_model));
`endif

      // Reset in the third beat of an 8-beat write: only two words land, no done.
      for (int i = 0; i < 4; i++) w[i] = $urandom;
      @(posedge clk); #1;
      for (int i = 1; i <= 2; i++) begin
         e.kind = 0; e.cyc = cyc + i; e.addr = AW'(7'h20 + i - 1); e.wr = 1'b1; e.data = w[i];
         shadow[e.addr] = w[i];
         exp_q.push_back(e);
      end
      cpu_rd = 1'b0; cpu_wr = 1'b0;
      dma_req = 1'b1; dma_wr = 1'b1; dma_addr = 7'h20; dma_len = 4'd7; dma_wdata = w[0];
      @(posedge clk); #1; dma_req = 1'b0; dma_wdata = w[1];
      @(posedge clk); #1; dma_wdata = w[2];
      @(posedge clk); #1; dma_wdata = w[3];
      #1; rst_n = 1'b0;
      #1;
      chk("abort_dma_gnt", 32'(dma_gnt), 32'd0);
      chk("abort_dma_ack", 32'(dma_ack), 32'd0);
      chk("abort_dma_done", 32'(dma_done), 32'd0);
      chk("abort_mem_wr", 32'(mem_wr), 32'd0);
`ifdef DM_ARB_STATS_EN
      chk("abort_stall_cnt", 32'(stall_cnt), 32'd0);
`endif
      @(negedge clk); #1;
      rst_n = 1'b1;
      idle(10);
      chk("abort_queue_drained", 32'(exp_q.size()), 32'd0);
      diff = 0;
      for (int i = 0; i < DEPTH; i++) if (dm[i] !== shadow[i]) diff++;
      chk("dm_words_off_model", 32'(diff), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      errors++;
      $display("FAIL watchdog at cycle %0d: got no end of test, expected completion", cyc);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
